// File: rtl/reduce_tree_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reduce_tree_pkg : operation modes and pair-combine helper            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package reduce_tree_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  function automatic logic op(input logic a, input logic b, input mode_e mode);
    logic r;
    case (mode)
      MODE_OR:  r = a | b;
      MODE_XOR: r = a ^ b;
      // NAND reduces with AND; only the final level inverts
      default:  r = a & b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_tree_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reduce_tree_stage : one registered IN_W -> IN_W/2 reduction level    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reduce_tree_stage
  import reduce_tree_pkg::*;
#(
  parameter int IN_W = 2,
  parameter bit LAST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [IN_W-1:0]   i_data,
  input  mode_e             i_mode,
  input  logic              i_next_ready,
  output logic              o_ready,
  output logic              o_valid,
  output logic [IN_W/2-1:0] o_data,
  output mode_e             o_mode
);

  localparam int OUT_W = IN_W / 2;

  logic [OUT_W-1:0] w_comb;
  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  mode_e            r_mode;

  always_comb begin
    w_comb = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_comb[i] = op(i_data[2*i], i_data[2*i+1], i_mode);
    end
    if (LAST && (i_mode == MODE_NAND)) begin
      w_comb = ~w_comb;
    end
  end

  // A stage can take a new word when empty or when its content moves on
  assign o_ready = !r_valid || i_next_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_AND;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_comb;
        r_mode <= i_mode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reduce_tree_pipe : pipelined AND/OR/XOR/NAND reduction tree with     |
// | valid/ready flow control. Optional out_count via REDUCE_TREE_CNT_EN. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reduce_tree_pipe
  import reduce_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data
`ifdef REDUCE_TREE_CNT_EN
  ,
  output logic [CNT_W-1:0] out_count
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [LEVELS:0] w_valid;
  logic [LEVELS:0] w_ready;
  mode_e           w_mode [LEVELS+1];
  // All stage outputs packed back to back; stage k sits at WIDTH-(WIDTH>>k)
  logic [WIDTH-2:0] w_data;

  assign w_valid[0]      = in_valid;
  assign w_mode[0]       = mode_e'(in_mode);
  assign w_ready[LEVELS] = out_ready;
  assign in_ready        = w_ready[0];

  generate
    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
      localparam int IN_W    = WIDTH >> k;
      localparam int OUT_OFS = WIDTH - IN_W;

      logic [IN_W-1:0] w_in;

      if (k == 0) begin : g_first
        assign w_in = in_data;
      end else begin : g_inner
        assign w_in = w_data[WIDTH-2*IN_W +: IN_W];
      end

      reduce_tree_stage #(
        .IN_W (IN_W),
        .LAST (k == LEVELS - 1)
      ) u_stage (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (w_valid[k]),
        .i_data       (w_in),
        .i_mode       (w_mode[k]),
        .i_next_ready (w_ready[k+1]),
        .o_ready      (w_ready[k]),
        .o_valid      (w_valid[k+1]),
        .o_data       (w_data[OUT_OFS +: IN_W/2]),
        .o_mode       (w_mode[k+1])
      );
    end
  endgenerate

  assign out_valid = w_valid[LEVELS];
  assign out_data  = w_data[WIDTH-2];

`ifdef REDUCE_TREE_CNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (out_valid && out_ready) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out_count = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reduce_tree_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reduce_tree_pipe : directed vector bench for reduce_tree_pipe     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reduce_tree_pipe;

  localparam int WIDTH  = 8;
  localparam int LEVELS = 3;
`ifdef REDUCE_TREE_CNT_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_data;

  logic             v2 = 1'b0;
  logic             in_ready2;
  logic [1:0]       d2 = '0;
  logic [1:0]       m2 = '0;
  logic             out_valid2;
  logic             out_data2;
`ifdef REDUCE_TREE_CNT_EN
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_count2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reduce_tree_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef REDUCE_TREE_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  reduce_tree_pipe #(.WIDTH(2), .CNT_W(CNT_W)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .in_ready  (in_ready2),
    .in_data   (d2),
    .in_mode   (m2),
    .out_valid (out_valid2),
    .out_ready (1'b1),
    .out_data  (out_data2)
`ifdef REDUCE_TREE_CNT_EN
    ,
    .out_count (out_count2)
`endif
  );

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic             exp;
  } vec_t;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] data;
    logic       exp;
  } vec2_t;

  vec_t  vecs [10];
  vec2_t vecs2 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] bp_words [5];
  logic             bp_exp   [5];

  initial begin
    int sent, got, n_hs;
    logic acc_in, acc_out, d_out;
    logic [15:0] rdy_pat;

    vecs[0] = '{2'b00, 8'hFF, 1'b1};
    vecs[1] = '{2'b00, 8'hFE, 1'b0};
    vecs[2] = '{2'b10, 8'h01, 1'b1};
    vecs[3] = '{2'b10, 8'h03, 1'b0};
    vecs[4] = '{2'b10, 8'h07, 1'b1};
    vecs[5] = '{2'b10, 8'h00, 1'b0};
    vecs[6] = '{2'b11, 8'hFF, 1'b0};
    vecs[7] = '{2'b11, 8'h7F, 1'b1};
    vecs[8] = '{2'b01, 8'h00, 1'b0};
    vecs[9] = '{2'b01, 8'h10, 1'b1};

    vecs2[0] = '{2'b00, 2'b11, 1'b1};
    vecs2[1] = '{2'b11, 2'b11, 1'b0};
    vecs2[2] = '{2'b10, 2'b01, 1'b1};
    vecs2[3] = '{2'b11, 2'b01, 1'b1};

    bp_words[0] = 8'hFF; bp_words[1] = 8'h00; bp_words[2] = 8'hFF;
    bp_words[3] = 8'h00; bp_words[4] = 8'hFF;
    bp_exp[0] = 1'b1; bp_exp[1] = 1'b0; bp_exp[2] = 1'b1;
    bp_exp[3] = 1'b0; bp_exp[4] = 1'b1;

    // reset state
    repeat (3) cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {31'b0, out_data},  32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
`ifdef REDUCE_TREE_CNT_EN
    chk("rst_count", {30'b0, out_count}, 32'd0);
`endif
    #2 rst_n = 1'b1;
    cyc();

    // back-to-back stream, one word per cycle, no stalls
    out_ready = 1'b1;
    for (int j = 0; j < 10 + LEVELS; j++) begin
      if (j < 10) begin
        in_valid = 1'b1;
        in_mode  = vecs[j].mode;
        in_data  = vecs[j].data;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (j < 10) chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (j - (LEVELS - 1) >= 0 && j - (LEVELS - 1) < 10) begin
        chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
        chk("stream_out_data", {31'b0, out_data}, {31'b0, vecs[j-(LEVELS-1)].exp});
      end else begin
        chk("stream_idle_valid", {31'b0, out_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;

    // backpressure: three words fill the pipe, the rest wait
    out_ready = 1'b0;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (c == 6) out_ready = 1'b1;
      in_valid = (sent < 5);
      in_mode  = 2'b00;
      in_data  = (sent < 5) ? bp_words[sent] : 8'h00;
      #1;
      if (c >= 3 && c <= 5) begin
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_head_held", {30'b0, out_valid, out_data}, 32'd3);
      end
      if (c == 3) chk("bp_accepted", sent, 3);
      if (c == 6) chk("bp_full_passthru", {31'b0, in_ready}, 32'd1);
      acc_in  = in_valid & in_ready;
      acc_out = out_valid & out_ready;
      d_out   = out_data;
      @(posedge clk); #1;
      if (acc_in) sent++;
      if (acc_out) begin
        if (got < 5) chk("bp_order", {31'b0, d_out}, {31'b0, bp_exp[got]});
        got++;
      end
    end
    in_valid = 1'b0;
    chk("bp_sent", sent, 5);
    chk("bp_got", got, 5);
    cyc();
    chk("bp_no_dup", {31'b0, out_valid}, 32'd0);

    // reset with two words in flight
    out_ready = 1'b0;
    in_mode   = 2'b00;
    in_data   = 8'hFF;
    in_valid  = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mr_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("mr_pre_data",  {31'b0, out_data},  32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_async_data",  {31'b0, out_data},  32'd0);
    chk("mr_in_ready",    {31'b0, in_ready},  32'd1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("mr_no_stale", {31'b0, out_valid}, 32'd0);
      chk("mr_ready_after", {31'b0, in_ready}, 32'd1);
    end

`ifdef REDUCE_TREE_CNT_EN
    // five handshakes with two interleaved stalls; 2-bit counter wraps to 1
    chk("cnt_after_rst", {30'b0, out_count}, 32'd0);
    rdy_pat = 16'b1111_1111_1101_0111;
    sent = 0;
    n_hs = 0;
    for (int c = 0; c < 16 && n_hs < 5; c++) begin
      logic [CNT_W-1:0] cnt_before;
      out_ready = rdy_pat[c];
      in_valid  = (sent < 5);
      in_mode   = 2'b01;
      in_data   = 8'h01;
      #1;
      acc_in     = in_valid & in_ready;
      acc_out    = out_valid & out_ready;
      cnt_before = out_count;
      @(posedge clk); #1;
      if (acc_in) sent++;
      if (acc_out) n_hs++;
      if (!rdy_pat[c]) chk("cnt_hold_stall", {30'b0, out_count}, {30'b0, cnt_before});
      else chk("cnt_track", {30'b0, out_count}, n_hs % 4);
    end
    in_valid = 1'b0;
    chk("cnt_handshakes", n_hs, 5);
    chk("cnt_wrapped", {30'b0, out_count}, 32'd1);
`endif

    // single-stage tree: latency 1, NAND inversion in stage 0
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin
        v2 = 1'b1;
        m2 = vecs2[j].mode;
        d2 = vecs2[j].data;
      end else begin
        v2 = 1'b0;
      end
      cyc();
      if (j < 4) begin
        chk("w2_valid", {31'b0, out_valid2}, 32'd1);
        chk("w2_data", {31'b0, out_data2}, {31'b0, vecs2[j].exp});
      end else begin
        chk("w2_idle", {31'b0, out_valid2}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
